// File: rtl/tournament_bp_if.sv
// Predict/update bundle between the IF/EX stages and the tournament predictor.
// ready flags that the post-reset table sweep has finished.
interface tournament_bp_if #(
    parameter int HIST_BITS = 6
);
    logic                 ready;
    logic [31:0]          pc_if;
    logic                 pred_valid;
    logic                 pred_taken;
    logic                 pred_local;
    logic                 pred_global;
    logic [HIST_BITS-1:0] pred_ghr;
    logic                 upd_valid;
    logic [31:0]          upd_pc;
    logic [HIST_BITS-1:0] upd_ghr;
    logic                 upd_taken;
    logic                 upd_mispred;

    modport master (
        input  ready, pred_taken, pred_local, pred_global, pred_ghr,
        output pc_if, pred_valid, upd_valid, upd_pc, upd_ghr,
        output upd_taken, upd_mispred
    );

    modport slave (
        output ready, pred_taken, pred_local, pred_global, pred_ghr,
        input  pc_if, pred_valid, upd_valid, upd_pc, upd_ghr,
        input  upd_taken, upd_mispred
    );
endinterface

// File: rtl/tournament_bp.sv
// Tournament branch predictor: local PHT, gshare PHT and per-entry chooser.
// Define SPEC_GHR_EN for a speculative GHR repaired on mispredict.
module tournament_bp #(
    parameter int IDX_BITS  = 6,
    parameter int HIST_BITS = 6,
    parameter int CTR_BITS  = 2
) (
    input  logic           clk,
    input  logic           rst,
    tournament_bp_if.slave bp
);

    localparam int N = 2 ** IDX_BITS;
    localparam logic [CTR_BITS-1:0] WEAK = CTR_BITS'(2 ** (CTR_BITS - 1) - 1);
    localparam logic [CTR_BITS-1:0] CMAX = '1;
    localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(N - 1);

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e               state_q, state_d;
    logic [IDX_BITS-1:0]  sweep_q, sweep_d;
    logic [HIST_BITS-1:0] ghr_q, ghr_d;

    logic [CTR_BITS-1:0] lpht_q [N];
    logic [CTR_BITS-1:0] gpht_q [N];
    logic [CTR_BITS-1:0] cho_q  [N];

    logic                run;
    logic [IDX_BITS-1:0] li, gi, uli, ugi;
    logic                p_local, p_global, p_taken;
    logic                u_lmsb, u_gmsb;
    logic [CTR_BITS-1:0] lpht_nx, gpht_nx, cho_nx;
    logic                unused_bits;

    function automatic logic [CTR_BITS-1:0] sat_step(
        input logic [CTR_BITS-1:0] c,
        input logic                up
    );
        if (up) return (c == CMAX) ? c : c + 1'b1;
        return (c == '0) ? c : c - 1'b1;
    endfunction

    assign run = (state_q == S_RUN);

    assign li  = bp.pc_if[IDX_BITS+1:2];
    assign gi  = li ^ IDX_BITS'(ghr_q);
    assign uli = bp.upd_pc[IDX_BITS+1:2];
    assign ugi = uli ^ IDX_BITS'(bp.upd_ghr);

    assign p_local  = lpht_q[li][CTR_BITS-1];
    assign p_global = gpht_q[gi][CTR_BITS-1];
    assign p_taken  = cho_q[li][CTR_BITS-1] ? p_global : p_local;

    assign bp.ready       = run;
    assign bp.pred_local  = run & p_local;
    assign bp.pred_global = run & p_global;
    assign bp.pred_taken  = run & p_taken;
    assign bp.pred_ghr    = run ? ghr_q : '0;

    // Chooser only learns when the two components disagree
    assign u_lmsb  = lpht_q[uli][CTR_BITS-1];
    assign u_gmsb  = gpht_q[ugi][CTR_BITS-1];
    assign lpht_nx = sat_step(lpht_q[uli], bp.upd_taken);
    assign gpht_nx = sat_step(gpht_q[ugi], bp.upd_taken);
    assign cho_nx  = (u_lmsb != u_gmsb)
                   ? sat_step(cho_q[uli], u_gmsb == bp.upd_taken)
                   : cho_q[uli];

    assign unused_bits = ^{bp.pc_if[31:IDX_BITS+2], bp.pc_if[1:0],
                           bp.upd_pc[31:IDX_BITS+2], bp.upd_pc[1:0],
                           bp.pred_valid, bp.upd_mispred};

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        ghr_d   = ghr_q;
        unique case (state_q)
            S_INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == LAST) state_d = S_RUN;
            end
            S_RUN: begin
`ifdef SPEC_GHR_EN
                if (bp.upd_valid && bp.upd_mispred)
                    ghr_d = {bp.upd_ghr[HIST_BITS-2:0], bp.upd_taken};
                else if (bp.pred_valid)
                    ghr_d = {ghr_q[HIST_BITS-2:0], p_taken};
`else
                if (bp.upd_valid)
                    ghr_d = {ghr_q[HIST_BITS-2:0], bp.upd_taken};
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INIT;
            sweep_q <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            ghr_q   <= ghr_d;
        end
    end

    // Tables are never reset; the INIT sweep owns their contents
    always_ff @(posedge clk) begin
        if (!run) begin
            lpht_q[sweep_q] <= WEAK;
            gpht_q[sweep_q] <= WEAK;
            cho_q[sweep_q]  <= WEAK;
        end else if (bp.upd_valid) begin
            lpht_q[uli] <= lpht_nx;
            gpht_q[ugi] <= gpht_nx;
            cho_q[uli]  <= cho_nx;
        end
    end

endmodule

// File: tb/tb_tournament_bp.sv
// Bench for tournament_bp: directed vector table, corner sequences and a
// randomized run against a counter-array reference model.
module tb_tournament_bp;

  localparam int IB = 6;
  localparam int HB = 6;
`ifdef SPEC_GHR_EN
  localparam int SNAP_GHR = 7;
`else
  localparam int SNAP_GHR = 15;
`endif

  logic clk;
  logic rst;

  tournament_bp_if #(.HIST_BITS(HB)) bp();

  tournament_bp #(
    .IDX_BITS (IB),
    .HIST_BITS(HB),
    .CTR_BITS (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_l [64];
  int m_g [64];
  int m_c [64];
  int m_ghr;
  bit m_run;

  typedef struct {
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic [5:0]  ughr;
    logic        ut;
    int          ck;
    logic        el;
    logic        eg;
    logic        et;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    input logic [31:0] pc, input logic uv,
    input logic [31:0] upc, input logic [5:0] ughr,
    input logic ut, input int ck,
    input logic el, input logic eg, input logic et);
    vec_t v;
    v.pc = pc; v.uv = uv; v.upc = upc; v.ughr = ughr;
    v.ut = ut; v.ck = ck; v.el = el; v.eg = eg; v.et = et;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int bump(input int v, input bit up);
    if (up) return (v < 3) ? v + 1 : 3;
    return (v > 0) ? v - 1 : 0;
  endfunction

  function automatic void m_init();
    for (int i = 0; i < 64; i++) begin
      m_l[i] = 1; m_g[i] = 1; m_c[i] = 1;
    end
    m_ghr = 0;
  endfunction

  function automatic void m_pred(input logic [31:0] pc,
                                 output bit pl, output bit pg,
                                 output bit pt);
    int li, gi;
    li = int'(pc >> 2) % 64;
    gi = li ^ m_ghr;
    pl = m_l[li] >= 2;
    pg = m_g[gi] >= 2;
    pt = (m_c[li] >= 2) ? pg : pl;
  endfunction

  function automatic void m_step();
    bit pl, pg, pt, lt, gt;
    int uli, ugi;
    m_pred(bp.pc_if, pl, pg, pt);
    if (bp.upd_valid) begin
      uli = int'(bp.upd_pc >> 2) % 64;
      ugi = uli ^ int'(bp.upd_ghr);
      lt = m_l[uli] >= 2;
      gt = m_g[ugi] >= 2;
      if (lt != gt) m_c[uli] = bump(m_c[uli], gt == bp.upd_taken);
      m_l[uli] = bump(m_l[uli], bp.upd_taken);
      m_g[ugi] = bump(m_g[ugi], bp.upd_taken);
    end
`ifdef SPEC_GHR_EN
    if (bp.upd_valid && bp.upd_mispred)
      m_ghr = (int'(bp.upd_ghr) * 2 + int'(bp.upd_taken)) % 64;
    else if (bp.pred_valid)
      m_ghr = (m_ghr * 2 + int'(pt)) % 64;
`else
    if (bp.upd_valid)
      m_ghr = (m_ghr * 2 + int'(bp.upd_taken)) % 64;
`endif
  endfunction

  task automatic drive(input logic [31:0] pc, input logic pv,
                       input logic uv, input logic [31:0] upc,
                       input logic [5:0] ughr, input logic ut,
                       input logic um);
    bp.pc_if = pc; bp.pred_valid = pv;
    bp.upd_valid = uv; bp.upd_pc = upc; bp.upd_ghr = ughr;
    bp.upd_taken = ut; bp.upd_mispred = um;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_run) m_step();
    #1;
  endtask

  task automatic idle();
    drive(32'h0, 1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string nm);
    idle();
    m_run = 1'b0;
    rst = 1'b0;
    #1;
    chk({nm, "_ready"}, 32'(bp.ready), 0);
    chk({nm, "_pred"},
        32'({bp.pred_taken, bp.pred_local, bp.pred_global}), 0);
    chk({nm, "_ghr"}, 32'(bp.pred_ghr), 0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (bp.ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, 32'(n), 64);
    m_init();
    m_run = 1'b1;
  endtask

  initial begin
    bit pl, pg, pt;
    logic [31:0] rpc, rupc;
    logic [5:0]  rghr;

    // Saturation of LPHT[16] via pc 0x40
    add(32'h40, 1, 32'h40, 0, 1, 1, 0, 0, 0);
    add(32'h40, 1, 32'h40, 0, 1, 1, 1, 0, 1);
    add(32'h40, 1, 32'h40, 0, 1, 1, 1, 0, 1);
    add(32'h40, 1, 32'h40, 0, 1, 1, 1, 0, 1);
    add(32'h40, 1, 32'h40, 0, 0, 1, 1, 0, 1);
    add(32'h40, 1, 32'h40, 0, 0, 1, 1, 0, 1);
    add(32'h40, 1, 32'h40, 0, 0, 1, 0, 0, 0);
    add(32'h40, 1, 32'h40, 0, 0, 1, 0, 0, 0);
    add(32'h40, 1, 32'h40, 0, 1, 1, 0, 0, 0);
    add(32'h40, 1, 32'h40, 0, 1, 1, 0, 0, 0);
    add(32'h40, 0, 32'h0,  0, 0, 1, 1, 0, 1);
    // Chooser at index 5: GPHT[5] primed taken, GHR flushed to 0
    add(32'h0, 1, 32'h24, 12, 1, 0, 0, 0, 0);
    add(32'h0, 1, 32'h24, 12, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(32'h0, 1, 32'h80, 0, 0, 0, 0, 0, 0);
    add(32'h14, 0, 32'h0,  0, 0, 2, 0, 1, 0);
    add(32'h14, 1, 32'h14, 0, 0, 2, 0, 1, 0);
    add(32'h0, 1, 32'h14, 20, 1, 0, 0, 0, 0);
    add(32'h0, 1, 32'h14, 24, 1, 0, 0, 0, 0);
    add(32'h0, 1, 32'h14, 28, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(32'h0, 1, 32'h80, 0, 0, 0, 0, 0, 0);
    add(32'h14, 0, 32'h0,  0, 0, 2, 1, 1, 1);
    add(32'h14, 1, 32'h14, 3, 0, 2, 1, 1, 1);
    add(32'h14, 1, 32'h14, 3, 0, 2, 1, 1, 1);
    add(32'h14, 0, 32'h0,  0, 0, 2, 0, 1, 1);

    m_run = 1'b0;
    rst = 1'b0;
    bp.pc_if = '0; bp.pred_valid = 1'b0; bp.upd_valid = 1'b0;
    bp.upd_pc = '0; bp.upd_ghr = '0; bp.upd_taken = 1'b0;
    bp.upd_mispred = 1'b0;
    @(posedge clk); #1;

    do_reset("reset");
    wait_ready("sweep_len");
    chk("ready_after_sweep", 32'(bp.ready), 1);

    for (int i = 0; i < 64; i++) begin
      drive(32'(i * 4), 1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
      chk($sformatf("init_entry%0d", i),
          32'({bp.pred_local, bp.pred_global, bp.pred_taken}), 0);
      tick();
    end

    foreach (vecs[i]) begin
      drive(vecs[i].pc, 1'b0, vecs[i].uv, vecs[i].upc,
            vecs[i].ughr, vecs[i].ut, 1'b0);
      if (vecs[i].ck != 0) begin
        chk($sformatf("vec%0d_local", i), 32'(bp.pred_local), 32'(vecs[i].el));
        chk($sformatf("vec%0d_taken", i), 32'(bp.pred_taken), 32'(vecs[i].et));
        if (vecs[i].ck == 2)
          chk($sformatf("vec%0d_global", i),
              32'(bp.pred_global), 32'(vecs[i].eg));
      end
      tick();
    end

    // Sweep abort at sweep cycle 30
    do_reset("abort_reset");
    repeat (30) begin @(posedge clk); #1; end
    chk("abort_mid_ready", 32'(bp.ready), 0);
    rst = 1'b0;
    #2;
    chk("abort_rst_ready", 32'(bp.ready), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_ready("abort_sweep_len");

    // GHR snapshot carried from predict to update
`ifdef SPEC_GHR_EN
    drive(32'h0, 0, 1, 32'h100, 6'd1, 1, 1); tick();
`else
    drive(32'h0, 0, 1, 32'h100, 6'd0, 1, 0); tick();
    drive(32'h0, 0, 1, 32'h100, 6'd0, 1, 0); tick();
`endif
    drive(32'h10, 1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    chk("snap_pred_ghr", 32'(bp.pred_ghr), 3);
    tick();
`ifdef SPEC_GHR_EN
    drive(32'h0, 0, 1, 32'h100, 6'd35, 1, 1); tick();
`else
    drive(32'h0, 0, 1, 32'h100, 6'd0, 1, 0); tick();
`endif
    drive(32'h0, 0, 1, 32'h10, 6'd3, 1, 0); tick();
    drive(32'((7 ^ SNAP_GHR) * 4), 0, 0, 32'h0, 6'd0, 0, 0);
    chk("snap_ghr_now", 32'(bp.pred_ghr), 32'(SNAP_GHR));
    chk("snap_gpht7_hit", 32'(bp.pred_global), 1);
    tick();
    drive(32'((3 ^ SNAP_GHR) * 4), 0, 0, 32'h0, 6'd0, 0, 0);
    chk("snap_gpht3_untouched", 32'(bp.pred_global), 0);
    tick();

    // GHR update policy
    do_reset("ghr_reset");
    wait_ready("ghr_sweep_len");
`ifdef SPEC_GHR_EN
    drive(32'h0, 0, 1, 32'h8, 6'd0, 1, 0); tick();
    drive(32'h8, 1, 0, 32'h0, 6'd0, 0, 0);
    chk("spec_nomis_ghr", 32'(bp.pred_ghr), 0);
    chk("spec_pred_taken", 32'(bp.pred_taken), 1);
    tick();
    drive(32'h8, 1, 1, 32'hC, 6'd2, 0, 1);
    chk("spec_shift_ghr", 32'(bp.pred_ghr), 1);
    tick();
    idle();
    chk("spec_repair_ghr", 32'(bp.pred_ghr), 4);
    tick();
`else
    drive(32'h0, 1, 0, 32'h0, 6'd0, 0, 0);
    chk("nspec_ghr_start", 32'(bp.pred_ghr), 0);
    tick();
    idle();
    chk("nspec_pv_no_effect", 32'(bp.pred_ghr), 0);
    tick();
    drive(32'h0, 0, 1, 32'h8, 6'd0, 1, 0); tick();
    idle();
    chk("nspec_upd_shift", 32'(bp.pred_ghr), 1);
    tick();
`endif

    // Randomized traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      rpc  = $urandom;
      rupc = ($urandom_range(0, 1) == 1) ? rpc : $urandom;
      rghr = ($urandom_range(0, 1) == 1) ? 6'(m_ghr) : 6'($urandom);
      drive(rpc, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), rupc, rghr,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      m_pred(rpc, pl, pg, pt);
      chk($sformatf("rand%0d", n),
          32'({bp.pred_local, bp.pred_global, bp.pred_taken, bp.pred_ghr}),
          32'({pl, pg, pt, 6'(m_ghr)}));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
